// File: rtl/dmem_if.sv
// Data-memory access channel between the LSU-side initiator and a memory responder.
// Valid/ready request channel plus a held response channel.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word loads/stores with byte enables, programmable wait states,
// and a held response channel. DM0/DM4/DM8 expose the first three words.
//
// state | meaning
// IDLE  | ready for a request; captures it on req_valid
// WAIT  | counting down wait states before the memory access
// RESP  | response held until rsp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    output logic [31:0] DM0,
    output logic [31:0] DM4,
    output logic [31:0] DM8
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WS_M1     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        do_access;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic [AW-1:0] acc_idx;

    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        do_access  = 1'b1;
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access  = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, straight from the bus.
    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_be    = cap_be;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W30);
        acc_idx = acc_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= 4'd0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_be      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                cap_we    <= bus.req_we;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cap_be    <= bus.req_be;
                cnt       <= WS_M1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (do_access) begin
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= '0;
                if (!acc_err) begin
                    if (acc_we) begin
                        for (int b = 0; b < 4; b++)
                            if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                    end else begin
                        rsp_rdata_q <= mem[acc_idx];
                    end
                end
            end
        end
    end

    assign bus.req_ready = rst && (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    generate
        if (DEPTH_WORDS > 0) begin : g_dm0
            assign DM0 = mem[0];
        end else begin : g_dm0_z
            assign DM0 = '0;
        end
        if (DEPTH_WORDS > 1) begin : g_dm4
            assign DM4 = mem[1];
        end else begin : g_dm4_z
            assign DM4 = '0;
        end
        if (DEPTH_WORDS > 2) begin : g_dm8
            assign DM8 = mem[2];
        end else begin : g_dm8_z
            assign DM8 = '0;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses come from a word-array model
// updated at issue time; a negedge monitor pops and compares each presented response.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();
    logic [31:0] dm0, dm4, dm8;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .DM0 (dm0),
        .DM4 (dm4),
        .DM8 (dm8)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          rr_random = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor
    bit   seen = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst || !bus.rsp_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata %h with no request outstanding", bus.rsp_rdata);
                cur.rdata = bus.rsp_rdata;
                cur.err   = bus.rsp_err;
            end else begin
                cur = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, cur.rdata);
                check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, cur.err});
                check("latency", 32'(cyc - cur.acc_cyc), 32'(WS));
            end
        end else begin
            check("hold_rdata", bus.rsp_rdata, cur.rdata);
            check("hold_err", {31'b0, bus.rsp_err}, {31'b0, cur.err});
            check("req_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rr_random) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   n;
        int   idx;
        idx     = int'(addr >> 2);
        e.err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
        e.rdata = (!e.err && !we) ? model[idx] : 32'h0;
        @(negedge clk);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
            bus.req_valid = 1'b0;
            return;
        end
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        if (we && !e.err)
            for (int b = 0; b < 4; b++)
                if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = $urandom_range(0, 1) != 0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid || !bus.req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: %0d responses still pending, required 0", exp_q.size());
        end
    endtask

    task automatic check_taps();
        wait_idle();
        check("dm0", dm0, model[0]);
        check("dm4", dm4, model[1]);
        check("dm8", dm8, model[2]);
    endtask

    initial begin
        int n;
        logic        we;
        logic [31:0] addr;
        int          sel;

        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_be    = 4'h0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("req_ready_during_rst", {31'b0, bus.req_ready}, 32'd0);
        check("rsp_valid_during_rst", {31'b0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", {31'b0, bus.req_ready}, 32'd1);
        check("rsp_valid_after_rst", {31'b0, bus.rsp_valid}, 32'd0);
        check("dm0_reset", dm0, 32'h0);
        check("dm4_reset", dm4, 32'h0);
        check("dm8_reset", dm8, 32'h0);

        // Full-word store then load
        bus.rsp_ready = 1'b1;
        issue(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        check_taps();
        check("dm4_deadbeef", dm4, 32'hDEAD_BEEF);

        // Byte-lane store
        issue(1'b1, 32'h8, 32'hAAAA_AAAA, 4'hF);
        issue(1'b1, 32'h8, 32'h1122_3344, 4'b0101);
        issue(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000);
        check_taps();
        check("dm8_lanes", dm8, 32'hAA22_AA44);

        // Error cases
        issue(1'b0, 32'h6, 32'h0, 4'h0);
        issue(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
        issue(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF);
        issue(1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
        issue(1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0);
        check_taps();

        // Response back-pressure
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1");
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h1234_5678;
        bus.req_be    = 4'hF;
        repeat (5) @(negedge clk);
        check("rsp_valid_held", {31'b0, bus.rsp_valid}, 32'd1);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_after_take", {31'b0, bus.rsp_valid}, 32'd0);
        check("req_ready_after_take", {31'b0, bus.req_ready}, 32'd1);
        check_taps();

        // Randomized traffic
        rr_random = 1'b1;
        repeat (60) begin
            sel = $urandom_range(0, 9);
            we  = $urandom_range(0, 1) != 0;
            if (sel < 3)      addr = 32'($urandom_range(0, 2) * 4);
            else if (sel < 6) addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel < 8) addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel < 9) addr = 32'(4 * DEPTH + 4 * $urandom_range(0, 7));
            else              addr = 32'h8000_0000 | ($urandom & 32'hFFFF_FFFC);
            issue(we, addr, $urandom, 4'($urandom_range(0, 15)));
        end
        rr_random = 1'b0;
        bus.rsp_ready = 1'b1;
        check_taps();

        // Reset while a store is waiting
        issue(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
        check_taps();
        issue(1'b1, 32'h0, 32'h0000_0005, 4'hF);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("dm0_after_abort", dm0, 32'h0);
        check("dm4_after_abort", dm4, 32'h0);
        check("req_ready_after_abort", {31'b0, bus.req_ready}, 32'd1);
        check("rsp_valid_after_abort", {31'b0, bus.rsp_valid}, 32'd0);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        check_taps();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
